vec_mem_unit: RTL and testbench
===============================

Name: vec_mem_unit

Overview:
- Multi-cycle vector load/store sequencer between the pipeline's memory stage and the 16-bit data memory.
- On a vector load it reads LANES consecutive halfwords and assembles the 256-bit vector that the datapath consumes as Vmemout.
- On a vector store it writes the LANES lanes of ValuoutM one halfword per cycle.
- Asserts busy so the hazard unit stalls the pipeline while a transfer runs.

Parameters:
- LANES, 16, number of vector lanes.
- LANE_W, 16, bits per lane; vector width = LANES*LANE_W (256).
- ADDR_STEP, 2, byte-address increment between consecutive lanes.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start_ld  input  1  request vector load; sampled in IDLE only.
- start_st  input  1  request vector store; sampled in IDLE only.
- bcast  input  1  broadcast-load qualifier for start_ld; only used with VMEM_BCAST_EN.
- base_addr  input  32  byte address of lane 0; captured on accepted start.
- vec_wdata  input  256  store vector (ValuoutM); captured on accepted start.
- mem_addr  output  32  data-memory address.
- mem_we  output  1  data-memory write enable.
- mem_wdata  output  16  data-memory write data.
- mem_rdata  input  16  data-memory read data; synchronous RAM, valid the cycle after the address is presented.
- Vmemout  output  256  assembled load vector.
- busy  output  1  transfer in progress; drives the stall.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Lane i occupies bits [16i+15:16i]. Lane i address = base_addr + i*ADDR_STEP, 32-bit modular; wraps past 0xFFFFFFFE without error.
- States: IDLE, LD, LD_LAST, ST, DONE.
  - busy=1 in LD, LD_LAST and ST.
  - busy=0 in IDLE and DONE; the pipeline releases in the cycle where done=1.
- Reset values: state=IDLE, lane counter=0, Vmemout=0, mem_addr=0, mem_we=0, mem_wdata=0, busy=0, done=0.
- IDLE:
  - start_ld=1 -> LD, counter=0, base_addr latched.
  - start_st=1 (with start_ld=0) -> ST, counter=0, base_addr and vec_wdata latched.
  - Both asserted: load wins and the store is dropped.
- LD:
  - mem_addr = lane address of counter; mem_we=0; counter increments each cycle.
  - From the second LD cycle onward, mem_rdata is written into lane counter-1 of the Vmemout shadow register.
  - After the address for lane LANES-1 is issued -> LD_LAST.
- LD_LAST:
  - Captures lane LANES-1; mem_addr holds the last address; -> DONE.
- ST:
  - mem_we=1, mem_addr = lane address of counter, mem_wdata = latched lane[counter].
  - After lane LANES-1 -> DONE.
- DONE:
  - done=1 for exactly one cycle, mem_we=0, -> IDLE.
  - Vmemout is updated atomically at entry to DONE, i.e. it changes only on load completion.
  - Vmemout holds its value through stores and idle cycles until the next load completes.
- Latency, counting from the start-accept edge:
  - Load: done high in cycle LANES+2 (18).
  - Store: done high in cycle LANES+1 (17).
  - Exactly LANES memory writes per store and LANES read addresses per load.
- start_ld/start_st asserted outside IDLE: ignored, no queuing. The pipeline is stalled, so this is not expected.
- A start asserted in the DONE cycle is ignored; a new request is accepted only in IDLE.
- Reset mid-transfer:
  - Returns to IDLE next edge; mem_we drops immediately in that cycle; Vmemout cleared to 0.
  - Partially written memory is left as is; done is not pulsed.

Optional Feature:
- Macro VMEM_BCAST_EN.
- Defined: start_ld with bcast=1 reads only lane-0 address.
  - Sequence is LD (1 cycle) -> LD_LAST -> DONE; done in cycle 3.
  - The halfword is replicated into all LANES lanes of Vmemout.
- Undefined: bcast is ignored and every load is a full LANES-halfword load.

Test Plan:
- Load:
  - Stimulus: memory holds halfword 0x1000+i at byte address 0x100+2i; start_ld, base_addr=0x100.
  - Response: busy for 17 cycles; done in cycle 18; Vmemout lane i = 0x1000+i; mem_we never 1.
- Store:
  - Stimulus: vec_wdata lane i = 0xA0A0+i; start_st, base_addr=0x200.
  - Response: mem_we=1 for 16 consecutive cycles at addresses 0x200..0x21E; data matches; done in cycle 17; Vmemout unchanged.
- Wrap:
  - Stimulus: load with base_addr=0xFFFFFFF8.
  - Response: lanes 0-3 addressed 0xFFFFFFF8..0xFFFFFFFE, lanes 4-15 addressed 0x0..0x16.
- Collisions:
  - start_ld and start_st together: load performed, no writes.
  - start_st pulsed during an active load: ignored.
- Reset mid-store:
  - Stimulus: assert reset after the 5th write.
  - Response: mem_we=0 that cycle; busy=0, done=0 and Vmemout=0 after the edge; exactly 5 writes occurred.
- Broadcast (VMEM_BCAST_EN):
  - Stimulus: mem[0x300]=0xBEEF; start_ld with bcast=1, base_addr=0x300.
  - Response: done in cycle 3; all 16 lanes = 0xBEEF.
  - With the macro off, the same stimulus performs a full 16-lane load.

Source files
------------

// File: rtl/vec_mem_unit.sv
// Vector load/store sequencer: moves LANES halfwords between the 16-bit data memory and a 256-bit vector.
// Optional broadcast load (single halfword replicated to every lane) is enabled by defining VMEM_BCAST_EN.
module vec_mem_unit #(
    parameter int LANES     = 16,
    parameter int LANE_W    = 16,
    parameter int ADDR_STEP = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_ld,
    input  logic                      start_st,
    input  logic                      bcast,
    input  logic [31:0]               base_addr,
    input  logic [LANES*LANE_W-1:0]   vec_wdata,
    output logic [31:0]               mem_addr,
    output logic                      mem_we,
    output logic [LANE_W-1:0]         mem_wdata,
    input  logic [LANE_W-1:0]         mem_rdata,
    output logic [LANES*LANE_W-1:0]   Vmemout,
    output logic                      busy,
    output logic                      done
);

    localparam int VW = LANES * LANE_W;
    localparam int SW = VW - LANE_W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD      = 3'd1,
        S_LD_LAST = 3'd2,
        S_ST      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [31:0]       r_mem_addr;
    logic              r_mem_we;
    logic [LANE_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic [SW-1:0]     r_shadow;
    logic [SW-1:0]     r_wvec;
    logic [VW-1:0]     r_vmem;

    state_t            w_next_state;
    logic [CW-1:0]     w_cnt_next;
    logic [31:0]       w_addr_next;
    logic              w_we_next;
    logic [LANE_W-1:0] w_wdata_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_accept_ld;
    logic              w_accept_st;
    logic              w_ld_last;
    logic              w_bcast_load;

    assign w_accept_ld = (r_state == S_IDLE) && start_ld;
    assign w_accept_st = (r_state == S_IDLE) && start_st && !start_ld;

`ifdef VMEM_BCAST_EN
    logic r_bcast;

    // Remember whether the accepted load is a broadcast load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcast <= 1'b0;
        end else if (w_accept_ld) begin
            r_bcast <= bcast;
        end else begin
            r_bcast <= r_bcast;
        end
    end

    assign w_bcast_load = r_bcast;
`else
    logic w_unused_bcast;
    assign w_unused_bcast = bcast;
    assign w_bcast_load   = 1'b0;
`endif

    assign w_ld_last = w_bcast_load || (r_cnt == LAST_LANE);

    // Next-state and next-output decode; outputs are registered so they line up with the new state.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_mem_addr;
        w_we_next    = 1'b0;
        w_wdata_next = r_mem_wdata;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_ld) begin
                    w_next_state = S_LD;
                    w_cnt_next   = CW'(0);
                    w_addr_next  = base_addr;
                    w_busy_next  = 1'b1;
                end else if (start_st) begin
                    w_next_state = S_ST;
                    w_cnt_next   = CW'(0);
                    w_addr_next  = base_addr;
                    w_we_next    = 1'b1;
                    w_wdata_next = vec_wdata[LANE_W-1:0];
                    w_busy_next  = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LD: begin
                w_busy_next = 1'b1;
                if (w_ld_last) begin
                    w_next_state = S_LD_LAST;
                end else begin
                    w_cnt_next  = r_cnt + CW'(1);
                    w_addr_next = r_mem_addr + 32'(ADDR_STEP);
                end
            end
            S_LD_LAST: begin
                w_next_state = S_DONE;
                w_done_next  = 1'b1;
            end
            S_ST: begin
                if (r_cnt == LAST_LANE) begin
                    w_next_state = S_DONE;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CW'(1);
                    w_addr_next  = r_mem_addr + 32'(ADDR_STEP);
                    w_we_next    = 1'b1;
                    w_wdata_next = r_wvec[LANE_W-1:0];
                    w_busy_next  = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, lane counter and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= CW'(0);
            r_mem_addr  <= 32'h0000_0000;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= {LANE_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_mem_addr  <= w_addr_next;
            r_mem_we    <= w_we_next;
            r_mem_wdata <= w_wdata_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    // Lanes stream through shift registers so no variable lane indexing is needed;
    // the visible vector is only written once the last lane arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wvec   <= {SW{1'b0}};
            r_shadow <= {SW{1'b0}};
            r_vmem   <= {VW{1'b0}};
        end else begin
            if (w_accept_st) begin
                r_wvec <= vec_wdata[VW-1:LANE_W];
            end else if (r_state == S_ST) begin
                r_wvec <= r_wvec >> LANE_W;
            end
            if ((r_state == S_LD) && (r_cnt != CW'(0))) begin
                r_shadow <= {mem_rdata, r_shadow[SW-1:LANE_W]};
            end
            if (r_state == S_LD_LAST) begin
                if (w_bcast_load) begin
                    r_vmem <= {LANES{mem_rdata}};
                end else begin
                    r_vmem <= {mem_rdata, r_shadow};
                end
            end
        end
    end

    // The write strobe is cut in the reset cycle itself so an aborted store issues no further write.
    assign mem_we    = r_mem_we & ~reset;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign Vmemout   = r_vmem;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed self-checking bench for vec_mem_unit with a synchronous-read halfword memory model.
module tb_vec_mem_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_ld;
    logic         start_st;
    logic         bcast;
    logic [31:0]  base_addr;
    logic [255:0] vec_wdata;
    logic [31:0]  mem_addr;
    logic         mem_we;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic [255:0] Vmemout;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    vec_mem_unit dut (
        .clk(clk), .reset(reset), .start_ld(start_ld), .start_st(start_st), .bcast(bcast),
        .base_addr(base_addr), .vec_wdata(vec_wdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .Vmemout(Vmemout), .busy(busy), .done(done)
    );

    logic [15:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = 10'd0;
    logic [15:0] pre_data = 16'd0;
    int          wr_n = 0;
    logic [31:0] wr_addr [0:255];
    logic [15:0] wr_data [0:255];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_we) mem[mem_addr[10:1]] <= mem_wdata;
        if (mem_we) begin
            if (wr_n < 256) begin
                wr_addr[wr_n] <= mem_addr;
                wr_data[wr_n] <= mem_wdata;
            end
            wr_n <= wr_n + 1;
        end
        mem_rdata <= mem[mem_addr[10:1]];
    end

    int total = 0;
    int bad = 0;
    int obs_done_cyc, obs_done_cnt, obs_busy, obs_we, obs_we_first, obs_we_last, rd_n;
    logic [31:0]  rd_log [0:63];
    logic [255:0] exp_load;

    task automatic write_mem(input logic [9:0] idx, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic run_xfer(input logic ld, input logic st, input logic bc,
                            input logic [31:0] a, input logic [255:0] wd, input int st_pulse);
        @(negedge clk);
        start_ld = ld; start_st = st; bcast = bc; base_addr = a; vec_wdata = wd;
        @(negedge clk);
        start_ld = 1'b0; start_st = 1'b0; bcast = 1'b0;
        obs_done_cyc = 0; obs_done_cnt = 0; obs_busy = 0; obs_we = 0;
        obs_we_first = 0; obs_we_last = 0; rd_n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy === 1'b1) obs_busy++;
            if (mem_we === 1'b1) begin
                obs_we++;
                if (obs_we_first == 0) obs_we_first = k;
                obs_we_last = k;
            end
            if (busy === 1'b1 && mem_we !== 1'b1 && rd_n < 64) begin
                rd_log[rd_n] = mem_addr;
                rd_n++;
            end
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_cyc == 0) obs_done_cyc = k;
            end
            start_st = (k == st_pulse);
            if (k < 40) @(negedge clk);
        end
        start_st = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_ld = 1'b0; start_st = 1'b0; bcast = 1'b0;
        base_addr = 32'h0; vec_wdata = 256'h0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
        total++; if (Vmemout !== 256'h0) begin bad++; $display("FAIL reset_vmem got=%h want=0", Vmemout); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        int wb;
        for (int i = 0; i < 16; i++) begin
            write_mem(10'h080 + 10'(i), 16'h1000 + 16'(i));
            exp_load[16*i +: 16] = 16'h1000 + 16'(i);
        end
        wb = wr_n;
        run_xfer(1'b1, 1'b0, 1'b0, 32'h0000_0100, 256'h0, 0);
        total++; if (obs_done_cyc != 18) begin bad++; $display("FAIL load_done_cycle got=%0d want=18", obs_done_cyc); end
        total++; if (obs_done_cnt != 1) begin bad++; $display("FAIL load_done_count got=%0d want=1", obs_done_cnt); end
        total++; if (obs_busy != 17) begin bad++; $display("FAIL load_busy_cycles got=%0d want=17", obs_busy); end
        total++; if (wr_n - wb != 0) begin bad++; $display("FAIL load_writes got=%0d want=0", wr_n - wb); end
        total++; if (rd_log[0] !== 32'h100) begin bad++; $display("FAIL load_addr0 got=%h want=100", rd_log[0]); end
        total++; if (rd_log[15] !== 32'h11E) begin bad++; $display("FAIL load_addr15 got=%h want=11e", rd_log[15]); end
        total++; if (Vmemout !== exp_load) begin bad++; $display("FAIL load_vmem got=%h want=%h", Vmemout, exp_load); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL load_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_store();
        int wb;
        logic [255:0] wd;
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'hA0A0 + 16'(i);
        wb = wr_n;
        run_xfer(1'b0, 1'b1, 1'b0, 32'h0000_0200, wd, 0);
        total++; if (obs_done_cyc != 17) begin bad++; $display("FAIL store_done_cycle got=%0d want=17", obs_done_cyc); end
        total++; if (obs_busy != 16) begin bad++; $display("FAIL store_busy_cycles got=%0d want=16", obs_busy); end
        total++; if (obs_we != 16 || obs_we_first != 1 || obs_we_last != 16) begin
            bad++; $display("FAIL store_we_window got=%0d/%0d..%0d want=16/1..16", obs_we, obs_we_first, obs_we_last);
        end
        total++; if (wr_n - wb != 16) begin bad++; $display("FAIL store_writes got=%0d want=16", wr_n - wb); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (wr_addr[wb+i] !== 32'h200 + 32'(2*i) || wr_data[wb+i] !== 16'hA0A0 + 16'(i)) begin
                bad++;
                $display("FAIL store_lane%0d got=%h:%h want=%h:%h", i, wr_addr[wb+i], wr_data[wb+i],
                         32'h200 + 32'(2*i), 16'hA0A0 + 16'(i));
            end
        end
        total++; if (Vmemout !== exp_load) begin bad++; $display("FAIL store_vmem_hold got=%h want=%h", Vmemout, exp_load); end
    endtask

    task automatic test_wrap();
        logic [31:0]  a;
        logic [255:0] exp_w;
        for (int i = 0; i < 16; i++) begin
            a = 32'hFFFF_FFF8 + 32'(2*i);
            write_mem(a[10:1], 16'h7700 + 16'(i));
            exp_w[16*i +: 16] = 16'h7700 + 16'(i);
        end
        run_xfer(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 256'h0, 0);
        for (int i = 0; i < 16; i++) begin
            a = 32'hFFFF_FFF8 + 32'(2*i);
            total++; if (rd_log[i] !== a) begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, rd_log[i], a); end
        end
        total++; if (obs_done_cyc != 18) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=18", obs_done_cyc); end
        total++; if (Vmemout !== exp_w) begin bad++; $display("FAIL wrap_vmem got=%h want=%h", Vmemout, exp_w); end
    endtask

    task automatic test_collision();
        int wb;
        wb = wr_n;
        run_xfer(1'b1, 1'b1, 1'b0, 32'h0000_0100, {16{16'h5555}}, 0);
        total++; if (wr_n - wb != 0) begin bad++; $display("FAIL both_writes got=%0d want=0", wr_n - wb); end
        total++; if (obs_done_cyc != 18) begin bad++; $display("FAIL both_done_cycle got=%0d want=18", obs_done_cyc); end
        total++; if (Vmemout !== exp_load) begin bad++; $display("FAIL both_vmem got=%h want=%h", Vmemout, exp_load); end
        wb = wr_n;
        run_xfer(1'b1, 1'b0, 1'b0, 32'h0000_0100, {16{16'h6666}}, 5);
        total++; if (wr_n - wb != 0) begin bad++; $display("FAIL midload_st_writes got=%0d want=0", wr_n - wb); end
        total++; if (obs_done_cnt != 1) begin bad++; $display("FAIL midload_done_count got=%0d want=1", obs_done_cnt); end
        wb = wr_n;
        run_xfer(1'b1, 1'b0, 1'b0, 32'h0000_0100, {16{16'h7777}}, 18);
        total++; if (wr_n - wb != 0) begin bad++; $display("FAIL donecyc_st_writes got=%0d want=0", wr_n - wb); end
        total++; if (obs_done_cnt != 1) begin bad++; $display("FAIL donecyc_done_count got=%0d want=1", obs_done_cnt); end
    endtask

    task automatic test_bcast();
        logic [255:0] exp_b;
        write_mem(10'h180, 16'hBEEF);
        for (int i = 1; i < 16; i++) write_mem(10'h180 + 10'(i), 16'hB000 + 16'(i));
`ifdef VMEM_BCAST_EN
        exp_b = {16{16'hBEEF}};
`else
        exp_b[15:0] = 16'hBEEF;
        for (int i = 1; i < 16; i++) exp_b[16*i +: 16] = 16'hB000 + 16'(i);
`endif
        run_xfer(1'b1, 1'b0, 1'b1, 32'h0000_0300, 256'h0, 0);
`ifdef VMEM_BCAST_EN
        total++; if (obs_done_cyc != 3) begin bad++; $display("FAIL bcast_done_cycle got=%0d want=3", obs_done_cyc); end
`else
        total++; if (obs_done_cyc != 18) begin bad++; $display("FAIL bcast_done_cycle got=%0d want=18", obs_done_cyc); end
`endif
        total++; if (Vmemout !== exp_b) begin bad++; $display("FAIL bcast_vmem got=%h want=%h", Vmemout, exp_b); end
    endtask

    task automatic test_reset_mid_store();
        int wb;
        wb = wr_n;
        @(negedge clk);
        start_st = 1'b1; base_addr = 32'h0000_0240; vec_wdata = {16{16'h1234}};
        @(negedge clk);
        start_st = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (wr_n - wb != 5) begin bad++; $display("FAIL rst_pre_writes got=%0d want=5", wr_n - wb); end
        reset = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we_same_cycle got=%b want=0", mem_we); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (Vmemout !== 256'h0) begin bad++; $display("FAIL rst_vmem got=%h want=0", Vmemout); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (wr_n - wb != 5) begin bad++; $display("FAIL rst_total_writes got=%0d want=5", wr_n - wb); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_wrap();
        test_collision();
        test_bcast();
        test_reset_mid_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
